// File: rtl/spc_ctl.sv
// ---------------------------------------------------------------------------
// spc_ctl : control block for the microcode subroutine (SPC) stack.
//
// Turns call/return and functional-destination/source requests into SPC
// memory strobes (swp/srp), pointer controls (spcnt/spush) and a stack
// occupancy count. A popped return address is captured in registers and
// announced with a one-cycle ret_valid pulse. Overflow, underflow and
// request conflicts are reported by sticky flags cleared with clr_err.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   state_write/state_fetch microinstruction write / fetch phase strobes
//   call_req, dst_push      push requests (return address / L bus data)
//   ret_req, src_pop        pop requests (popj / M source with pop)
//   lpc                     next sequential microinstruction address
//   l_in                    L bus data for dst_push
//   spco                    SPC read data
//   clr_err                 clears ovf/unf/conflict
//   spcw                    SPC write data
//   spcnt, spush            pointer count enable and direction
//   swp, srp                SPC write pulse / read pulse
//   ret_pc, ret_flags       registered return address and flag bits
//   ret_valid               one-cycle pulse after ret_pc/ret_flags load
//   depth                   stack occupancy, 0..DEPTH
//   ovf, unf, conflict      sticky error flags
// ---------------------------------------------------------------------------
module spc_ctl #(
  parameter int PC_W  = 14,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    state_write,
  input  logic                    state_fetch,
  input  logic                    call_req,
  input  logic                    ret_req,
  input  logic                    dst_push,
  input  logic                    src_pop,
  input  logic [PC_W-1:0]         lpc,
  input  logic [PC_W+4:0]         l_in,
  input  logic [PC_W+4:0]         spco,
  input  logic                    clr_err,
  output logic [PC_W+4:0]         spcw,
  output logic                    spcnt,
  output logic                    spush,
  output logic                    swp,
  output logic                    srp,
  output logic [PC_W-1:0]         ret_pc,
  output logic [4:0]              ret_flags,
  output logic                    ret_valid,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    ovf,
  output logic                    unf,
  output logic                    conflict
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2} op_t;

  state_t         state_r, state_nxt_s;
  op_t            op_r, op_req_s;
  logic           push_s, pop_s, accept_s, fetch_done_s;
  logic           ovf_set_s, unf_set_s, conflict_set_s;
  logic [DW-1:0]  depth_r;
  logic [PC_W-1:0] ret_pc_r;
  logic [4:0]     ret_flags_r;
  logic           ret_valid_r, ovf_r, unf_r, conflict_r;

  // Request decode: a pop always beats a simultaneous push.
  always_comb begin
    push_s   = call_req | dst_push;
    pop_s    = ret_req | src_pop;
    op_req_s = OP_NONE;
    if (pop_s) begin
      op_req_s = OP_POP;
    end else if (push_s) begin
      op_req_s = OP_PUSH;
    end else begin
      op_req_s = OP_NONE;
    end
    // A write is only taken from IDLE; a write seen in PEND means the fetch was missed.
    accept_s       = (state_r == IDLE) & state_write;
    fetch_done_s   = (state_r == PEND) & state_fetch;
    conflict_set_s = state_write & ((push_s & pop_s) | (state_r == PEND));
    ovf_set_s      = fetch_done_s & (op_r == OP_PUSH) & (depth_r == DEPTH_MAX);
    unf_set_s      = fetch_done_s & (op_r == OP_POP) & (depth_r == DEPTH_ZERO);
  end

  // SPC write data and memory strobes; data from the L bus takes precedence over lpc.
  always_comb begin
    spcw = {5'b00000, lpc};
    if (dst_push) begin
      spcw = l_in;
    end else begin
      spcw = {5'b00000, lpc};
    end
    swp = state_write & push_s & ~pop_s & ~reset;
    srp = state_write & pop_s & ~reset;
  end

  // FSM next state and pointer controls decoded from the current state.
  always_comb begin
    state_nxt_s = state_r;
    spcnt       = 1'b0;
    spush       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (op_req_s != OP_NONE)) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND: begin
        spcnt = ~reset;
        spush = ~reset & (op_r == OP_PUSH);
        if (state_fetch) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and latched operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= OP_NONE;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_r <= op_req_s;
      end
    end
  end

  // Occupancy count: saturates at both ends while the SPC pointer still moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_r <= DEPTH_ZERO;
    end else if (fetch_done_s && (op_r == OP_PUSH) && (depth_r != DEPTH_MAX)) begin
      depth_r <= depth_r + DEPTH_ONE;
    end else if (fetch_done_s && (op_r == OP_POP) && (depth_r != DEPTH_ZERO)) begin
      depth_r <= depth_r - DEPTH_ONE;
    end
  end

  // Return address capture at the write phase of an accepted pop, even when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_pc_r    <= '0;
      ret_flags_r <= 5'b00000;
      ret_valid_r <= 1'b0;
    end else begin
      ret_valid_r <= accept_s & pop_s;
      if (accept_s && pop_s) begin
        ret_pc_r    <= spco[PC_W-1:0];
        ret_flags_r <= spco[PC_W+4:PC_W];
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      ovf_r      <= ovf_set_s      | (ovf_r      & ~clr_err);
      unf_r      <= unf_set_s      | (unf_r      & ~clr_err);
      conflict_r <= conflict_set_s | (conflict_r & ~clr_err);
    end
  end

  assign depth     = depth_r;
  assign ret_pc    = ret_pc_r;
  assign ret_flags = ret_flags_r;
  assign ret_valid = ret_valid_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;
  assign conflict  = conflict_r;

endmodule

// File: tb/tb_spc_ctl.sv
// ---------------------------------------------------------------------------
// tb_spc_ctl : scoreboard bench for spc_ctl. Stimulus tasks queue the
// expected return word and expected pointer direction; monitor processes
// pop and compare when ret_valid pulses or spcnt rises.
// ---------------------------------------------------------------------------
module tb_spc_ctl;
  localparam int PC_W = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        state_write = 1'b0, state_fetch = 1'b0;
  logic        call_req = 1'b0, ret_req = 1'b0, dst_push = 1'b0, src_pop = 1'b0;
  logic [13:0] lpc = 14'h0000;
  logic [18:0] l_in = 19'h00000, spco = 19'h00000;
  logic        clr_err = 1'b0;
  logic [18:0] spcw;
  logic        spcnt, spush, swp, srp;
  logic [13:0] ret_pc;
  logic [4:0]  ret_flags;
  logic        ret_valid;
  logic [5:0]  depth;
  logic        ovf, unf, conflict;

  int n_checks = 0;
  int n_pass   = 0;
  logic [18:0] ret_q[$];
  logic        pend_q[$];

  spc_ctl #(.PC_W(PC_W), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .state_write(state_write), .state_fetch(state_fetch),
    .call_req(call_req), .ret_req(ret_req), .dst_push(dst_push), .src_pop(src_pop),
    .lpc(lpc), .l_in(l_in), .spco(spco), .clr_err(clr_err),
    .spcw(spcw), .spcnt(spcnt), .spush(spush), .swp(swp), .srp(srp),
    .ret_pc(ret_pc), .ret_flags(ret_flags), .ret_valid(ret_valid),
    .depth(depth), .ovf(ovf), .unf(unf), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: return word on each ret_valid cycle, pointer direction on each PEND entry.
  initial begin
    logic prev_cnt;
    logic [18:0] e;
    prev_cnt = 1'b0;
    forever begin
      @(negedge clk);
      if (ret_valid === 1'b1) begin
        if (ret_q.size() == 0) check("ret_valid_unexpected", {31'd0, ret_valid}, 32'd0);
        else begin
          e = ret_q.pop_front();
          check("ret_word", {13'd0, ret_flags, ret_pc}, {13'd0, e});
        end
      end
      if (spcnt === 1'b1 && !prev_cnt) begin
        if (pend_q.size() == 0) check("spcnt_unexpected", {31'd0, spcnt}, 32'd0);
        else check("spush_in_pend", {31'd0, spush}, {31'd0, pend_q.pop_front()});
      end
      prev_cnt = (spcnt === 1'b1);
    end
  end

  // One full microinstruction: write phase, fetch phase, DONE, back to IDLE.
  task automatic do_op(input string tag, input logic c, input logic r, input logic dp,
                       input logic sp, input logic [13:0] lp, input logic [18:0] li,
                       input logic [18:0] so, input logic [18:0] exp_spcw,
                       input logic exp_swp, input logic exp_srp, input logic [5:0] exp_depth);
    if (r | sp) begin
      ret_q.push_back(so);
      pend_q.push_back(1'b0);
    end else if (c | dp) begin
      pend_q.push_back(1'b1);
    end
    @(posedge clk); #1;
    call_req = c; ret_req = r; dst_push = dp; src_pop = sp;
    lpc = lp; l_in = li; spco = so; state_write = 1'b1;
    @(negedge clk);
    check({tag, "_swp"}, {31'd0, swp}, {31'd0, exp_swp});
    check({tag, "_srp"}, {31'd0, srp}, {31'd0, exp_srp});
    if (exp_swp) check({tag, "_spcw"}, {13'd0, spcw}, {13'd0, exp_spcw});
    @(posedge clk); #1;
    call_req = 1'b0; ret_req = 1'b0; dst_push = 1'b0; src_pop = 1'b0;
    state_write = 1'b0; state_fetch = 1'b1;
    @(negedge clk);
    check({tag, "_swp_fetch"}, {30'd0, swp, srp}, 32'd0);
    @(posedge clk); #1;
    state_fetch = 1'b0;
    @(posedge clk); #1;
    check({tag, "_depth"}, {26'd0, depth}, {26'd0, exp_depth});
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_depth", {26'd0, depth}, 32'd0);
    check("rst_flags", {28'd0, ovf, unf, conflict, ret_valid}, 32'd0);
    check("rst_ctrl", {28'd0, spcnt, spush, swp, srp}, 32'd0);
    check("rst_ret", {13'd0, ret_flags, ret_pc}, 32'd0);

    // L bus push then popj returning its fields
    do_op("dpush", 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 19'h7A555, 19'h00000,
          19'h7A555, 1'b1, 1'b0, 6'd1);
    do_op("ret", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 19'h00000, 19'h7A555,
          19'h00000, 1'b0, 1'b1, 6'd0);
    check("ret_pc_2555", {18'd0, ret_pc}, 32'h2555);
    check("ret_flags_1e", {27'd0, ret_flags}, 32'h1E);

    // Call pushes {0,lpc}
    do_op("call", 1'b1, 1'b0, 1'b0, 1'b0, 14'h0123, 19'h00000, 19'h00000,
          19'h00123, 1'b1, 1'b0, 6'd1);
    do_op("srcpop", 1'b0, 1'b0, 1'b0, 1'b1, 14'h0000, 19'h00000, 19'h00123,
          19'h00000, 1'b0, 1'b1, 6'd0);

    // 33 calls: saturation and overflow on the last
    for (int i = 0; i < 33; i++) begin
      do_op("fill", 1'b1, 1'b0, 1'b0, 1'b0, 14'(i), 19'h00000, 19'h00000,
            19'(i), 1'b1, 1'b0, (i < 32) ? 6'(i + 1) : 6'd32);
      if (i >= 31) check("fill_ovf", {31'd0, ovf}, (i == 32) ? 32'd1 : 32'd0);
    end
    pulse_clr();
    @(negedge clk);
    check("clr_ovf", {31'd0, ovf}, 32'd0);
    check("clr_depth", {26'd0, depth}, 32'd32);

    // Simultaneous call and popj: pop wins
    do_op("both", 1'b1, 1'b1, 1'b0, 1'b0, 14'h1111, 19'h00000, 19'h0ABCD,
          19'h01111, 1'b0, 1'b1, 6'd31);
    check("both_conflict", {31'd0, conflict}, 32'd1);
    pulse_clr();
    @(negedge clk);
    check("clr_conflict", {31'd0, conflict}, 32'd0);

    // Reset between write and fetch of a push
    @(posedge clk); #1 call_req = 1'b1; lpc = 14'h0055; state_write = 1'b1;
    @(posedge clk); #1 call_req = 1'b0; state_write = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rstmid_spcnt", {30'd0, spcnt, spush}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_depth", {26'd0, depth}, 32'd0);
    do_op("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 14'h3FFF, 19'h00000, 19'h00000,
          19'h03FFF, 1'b1, 1'b0, 6'd1);

    // Second write while PEND is ignored; only one pointer move
    pend_q.push_back(1'b1);
    @(posedge clk); #1 call_req = 1'b1; lpc = 14'h0AAA; state_write = 1'b1;
    @(posedge clk); #1 lpc = 14'h0BBB;
    @(posedge clk); #1 call_req = 1'b0; state_write = 1'b0; state_fetch = 1'b1;
    @(negedge clk);
    check("miss_fetch_conflict", {31'd0, conflict}, 32'd1);
    @(posedge clk); #1 state_fetch = 1'b0;
    @(posedge clk); #1;
    check("miss_fetch_depth", {26'd0, depth}, 32'd2);
    pulse_clr();

    // Drain, then underflow
    do_op("drain1", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 19'h00000, 19'h00001,
          19'h00000, 1'b0, 1'b1, 6'd1);
    do_op("drain2", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 19'h00000, 19'h00002,
          19'h00000, 1'b0, 1'b1, 6'd0);
    check("pre_unf", {29'd0, ovf, unf, conflict}, 32'd0);
    do_op("unf", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000, 19'h00000, 19'h5ABCD,
          19'h00000, 1'b0, 1'b1, 6'd0);
    check("unf_flag", {31'd0, unf}, 32'd1);
    check("unf_ret_pc", {18'd0, ret_pc}, 32'h2BCD);
    check("unf_ret_flags", {27'd0, ret_flags}, 32'h16);

    repeat (4) @(posedge clk);
    #1;
    check("ret_q_empty", ret_q.size(), 32'd0);
    check("pend_q_empty", pend_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
